// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format and a small input FIFO.
// Frames are drained from the FIFO back-to-back, paced by the external baud tick.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 write_en,
    input  logic [DATA_BITS-1:0] tx_in,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 full,
    output logic                 overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam bit            HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    // full comes from the registered count, so a same-cycle pop never frees room
    assign full     = (count_q == DEPTH_C);
    assign push     = write_en && !full;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign overflow = ovf_q;
    assign tx_out   = tx_q;
    assign busy     = (state_q != IDLE) || (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ovf_q   <= write_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= tx_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = START;
                shift_d = head;
                idx_d   = '0;
                stop_d  = 1'b0;
                par_d   = (^head) ^ ODD;
            end
            START: if (tx_en) state_d = DATA;
            DATA: if (tx_en) begin
                if (idx_q == LAST_IDX) begin
                    state_d = HAS_PAR ? PARITY : STOP;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: if (tx_en) state_d = STOP;
            STOP: if (tx_en) begin
                if (stop_q == STOP_LAST) state_d = IDLE;
                else                     stop_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line value for the bit that begins on this edge
    always_comb begin
        tx_d = tx_q;
        case (state_q)
            IDLE:  tx_d = !pop;
            START: if (tx_en) tx_d = shift_q[0];
            DATA: if (tx_en) begin
                if (idx_q == LAST_IDX) tx_d = HAS_PAR ? par_q : 1'b1;
                else                   tx_d = shift_q[1];
            end
            PARITY: if (tx_en) tx_d = 1'b1;
            STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter: next generation of the team's 8-bit TX. Adds configurable data width, optional odd/even parity, 1 or 2 stop bits, and a small input FIFO so the host can queue words while a frame is on the line. Baud timing comes from an external one-cycle tick (tx_en) produced by the shared baud generator. Frames are sent back-to-back from the FIFO with no host intervention.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9.
PARITY_EN, 0, 1 = append one parity bit after data.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, stop bits per frame, legal 1 or 2.
FIFO_DEPTH, 4, input FIFO entries, power of two, at least 2.

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
tx_en  in  1  baud tick, one clk cycle wide, once per bit period
write_en  in  1  host push strobe for tx_in
tx_in  in  DATA_BITS  word to queue
tx_out  out  1  serial line, idles high, registered
busy  out  1  high while FIFO non-empty or state != IDLE
full  out  1  FIFO holds FIFO_DEPTH entries
overflow  out  1  one-cycle pulse: write_en while full, word dropped

Behaviour:
- Reset (sync, active-high): state=IDLE, tx_out=1, FIFO emptied (pointers and count 0), busy=0, full=0, overflow=0. Reset mid-frame aborts the frame immediately; line high on next cycle; queued words discarded.
- FIFO: write_en with full=0 stores tx_in at the write pointer; count+1 next cycle. write_en with full=1: word dropped, overflow=1 next cycle for exactly one cycle, FIFO unchanged. Pointers wrap modulo FIFO_DEPTH. full is evaluated on the registered count at the start of the cycle: a same-cycle pop does not free space for a write while full. Simultaneous push and pop with count not full: count unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. If FIFO non-empty: pop head into shift register, index=0, stop count=0, go to START; tx_out<=0 on the same edge. tx_en is ignored in IDLE.
- START: hold 0. On tx_en: go to DATA, tx_out<=data[0].
- DATA: LSB first. On tx_en: if index==DATA_BITS-1, go to PARITY with tx_out<=parity bit (PARITY_EN=1), else go to STOP with tx_out<=1. Otherwise index+1 and tx_out<=data[index+1].
- PARITY: parity bit = XOR of the DATA_BITS data bits, inverted when PARITY_ODD=1. On tx_en: go to STOP, tx_out<=1.
- STOP: hold 1. On tx_en: if stop count==STOP_BITS-1 go to IDLE, else stop count+1.
- Each bit lasts from entry into its state until the next tx_en, so with a periodic tick every bit after START is exactly one tick period long. START lasts until the first tick after the pop.
- Latency: write_en at cycle N into an empty FIFO with the block in IDLE: FIFO non-empty at N+1, pop at N+1, tx_out=0 from N+2.
- Back-to-back: after the last stop bit the block spends exactly one cycle in IDLE (line high), then starts the next queued word.
- tx_en arriving in the pop cycle does not shorten START; START always waits for a tick strictly after entry.
- busy = (state != IDLE) or (count != 0). Combinational from registered state.

Test Plan:
- 8N1 defaults, tick every 16 cycles, write 0xA5 -> tx_out low 2 cycles after write, then per tick 1,0,1,0,0,1,0,1, then stop 1; busy falls the cycle after the stop tick.
- PARITY_EN=1, PARITY_ODD=0, write 0x07 -> parity bit 1; PARITY_ODD=1, write 0x07 -> parity bit 0; frame is 11 bit periods including start.
- STOP_BITS=2, DATA_BITS=7, write 0x55 -> two full tick periods high after bit 6 before IDLE; total frame is 10 bit periods.
- FIFO_DEPTH=4, tx_en held 0, write 0x11..0x16 on consecutive cycles -> 0x11 popped into the shifter, 0x12..0x15 queued, full=1; 0x16 dropped with a single overflow pulse. Then enable ticks -> frames 0x11..0x15 sent in order, each separated by one idle cycle.
- Assert reset during DATA bit 3 of 0x3C with 2 words queued -> next cycle tx_out=1, busy=0, full=0; no further frames; next write after reset transmits normally.
- Write while the FIFO has one free slot and a pop occurs in the same cycle -> word accepted, count unchanged, no overflow.
